// File: rtl/core_exec_pkg.sv
// Shared slot-field layout, aging function and saturating counter helper
// for the CORE execution emulator.
package core_exec_pkg;

    localparam int SLOT_W   = 42;
    localparam int RUN_BIT  = 41;
    localparam int CRIT_BIT = 40;
    localparam int ID_HI    = 39;
    localparam int ID_LO    = 32;
    localparam int DL_HI    = 31;
    localparam int DL_LO    = 16;
    localparam int EX_HI    = 15;
    localparam int EX_LO    = 0;

    typedef struct packed {
        logic [SLOT_W-1:0] slot;
        logic              retire;
        logic              late;
    } age_t;

    // One tick of aging; decrements only happen on operands >= 2, so no wrap.
    function automatic age_t age_slot(input logic [SLOT_W-1:0] s);
        age_t        r;
        logic [15:0] e;
        logic [15:0] d;
        e        = s[EX_HI:EX_LO];
        d        = s[DL_HI:DL_LO];
        r.slot   = s;
        r.retire = 1'b0;
        r.late   = 1'b0;
        if (s[RUN_BIT] == 1'b0) begin
            r.slot = s;
        end else if ((e <= 16'd1) || (d <= 16'd1)) begin
            r.slot[RUN_BIT]     = 1'b0;
            r.slot[DL_HI:DL_LO] = 16'd0;
            r.slot[EX_HI:EX_LO] = 16'd0;
            r.retire            = 1'b1;
            r.late              = (d == 16'd0) || (e > 16'd1);
        end else begin
            r.slot[DL_HI:DL_LO] = d - 16'd1;
            r.slot[EX_HI:EX_LO] = e - 16'd1;
        end
        return r;
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[16]) begin
            return 16'hFFFF;
        end else begin
            return s[15:0];
        end
    endfunction

endpackage

// File: rtl/core_executor_arbiter.sv
// Round-robin first-one picker: lowest set pend bit at or above the pointer,
// wrapping modulo N (N is a power of two).
module completion_arbiter #(
    parameter int N  = 16,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_pend,
    input  logic [PW-1:0] i_rr_ptr,
    output logic [PW-1:0] o_sel,
    output logic          o_any
);

    // Rotating scan from the pointer; first hit wins.
    always_comb begin
        logic [PW-1:0] idx;
        logic          found;
        o_sel = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = i_rr_ptr + PW'(i);
            if (!found && i_pend[idx]) begin
                o_sel = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        o_any = |i_pend;
    end

endmodule

// File: rtl/core_executor.sv
// Emulates CORE execution: periodic subtract tick, per-slot aging/retirement,
// and a round-robin completion event port with miss/drop statistics.
module core_executor
    import core_exec_pkg::*;
#(
    parameter int W        = SLOT_W,
    parameter int CORE     = 16,
    parameter int TICK_DIV = 16,
    parameter int CW       = $clog2(CORE),
    parameter int TW       = $clog2(TICK_DIV)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [W*CORE-1:0] i_slots_in,
    output logic [W*CORE-1:0] o_slots_out,
    output logic              o_tick,
    output logic              o_done_valid,
    input  logic              i_done_ready,
    output logic [CW-1:0]     o_done_core,
    output logic [7:0]        o_done_id,
    output logic              o_done_late,
    output logic [15:0]       o_miss_count,
    output logic [15:0]       o_drop_count
);

    logic [TW-1:0]   r_cnt;
    logic            r_tick;
    logic [CORE-1:0] r_pend;
    logic [7:0]      r_id [CORE];
    logic [CORE-1:0] r_late;
    logic [CW-1:0]   r_rr;
    logic [15:0]     r_miss;
    logic [15:0]     r_drop;

    age_t            w_age [CORE];
    logic [CORE-1:0] w_ret;
    logic [CORE-1:0] w_late;
    logic [CORE-1:0] w_store;
    logic [CORE-1:0] w_clr;
    logic [15:0]     w_miss_inc;
    logic [15:0]     w_drop_inc;
    logic [CW-1:0]   w_sel;
    logic            w_any;
    logic            w_accept;

    completion_arbiter #(.N(CORE), .PW(CW)) u_arb (
        .i_pend   (r_pend),
        .i_rr_ptr (r_rr),
        .o_sel    (w_sel),
        .o_any    (w_any)
    );

    assign w_accept     = w_any && i_done_ready;
    assign o_tick       = r_tick;
    assign o_done_valid = w_any;
    assign o_done_core  = w_sel;
    assign o_done_id    = r_id[w_sel];
    assign o_done_late  = r_late[w_sel];
    assign o_miss_count = r_miss;
    assign o_drop_count = r_drop;

    // Aging of every slot and per-core capture/drop decisions for this edge.
    always_comb begin
        o_slots_out = '0;
        w_ret       = '0;
        w_late      = '0;
        w_store     = '0;
        w_clr       = '0;
        w_miss_inc  = 16'd0;
        w_drop_inc  = 16'd0;
        for (int c = 0; c < CORE; c++) begin
            w_age[c]               = age_slot(i_slots_in[W*c +: W]);
            o_slots_out[W*c +: W]  = w_age[c].slot;
            w_ret[c]               = w_age[c].retire;
            w_late[c]              = w_age[c].late;
            w_clr[c]               = w_accept && (w_sel == CW'(c));
            // An accept on the same core frees the entry, so the new capture lands.
            w_store[c]             = r_tick && w_ret[c] && (!r_pend[c] || w_clr[c]);
            w_miss_inc             = w_miss_inc + {15'd0, w_store[c] & w_late[c]};
            w_drop_inc             = w_drop_inc + {15'd0, r_tick & w_ret[c] & r_pend[c] & ~w_clr[c]};
        end
    end

    // Tick divider: strobe for one cycle after each wrap of the counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (i_en) begin
            if (r_cnt == TW'(TICK_DIV - 1)) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + TW'(1);
                r_tick <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    // Pending event store, round-robin pointer and statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
            r_late <= '0;
            r_rr   <= '0;
            r_miss <= 16'd0;
            r_drop <= 16'd0;
            for (int c = 0; c < CORE; c++) begin
                r_id[c] <= 8'd0;
            end
        end else begin
            for (int c = 0; c < CORE; c++) begin
                if (w_store[c]) begin
                    r_pend[c] <= 1'b1;
                    r_id[c]   <= i_slots_in[W*c+ID_LO +: 8];
                    r_late[c] <= w_late[c];
                end else if (w_clr[c]) begin
                    r_pend[c] <= 1'b0;
                end else begin
                    r_pend[c] <= r_pend[c];
                end
            end
            if (w_accept) begin
                r_rr <= w_sel + CW'(1);
            end else begin
                r_rr <= r_rr;
            end
            r_miss <= sat_add16(r_miss, w_miss_inc);
            r_drop <= sat_add16(r_drop, w_drop_inc);
        end
    end

endmodule

// File: tb/tb_core_executor.sv
// Directed self-checking bench for core_executor (CORE=16, TICK_DIV=4).
module tb_core_executor;

    localparam int W    = 42;
    localparam int CORE = 16;
    localparam int TDIV = 4;

    logic              clk;
    logic              rst;
    logic              en;
    logic [W*CORE-1:0] slots_in;
    logic [W*CORE-1:0] slots_out;
    logic              tick;
    logic              done_valid;
    logic              done_ready;
    logic [3:0]        done_core;
    logic [7:0]        done_id;
    logic              done_late;
    logic [15:0]       miss_count;
    logic [15:0]       drop_count;

    int n_tests;
    int n_fail;

    core_executor #(.CORE(CORE), .TICK_DIV(TDIV)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_en         (en),
        .i_slots_in   (slots_in),
        .o_slots_out  (slots_out),
        .o_tick       (tick),
        .o_done_valid (done_valid),
        .i_done_ready (done_ready),
        .o_done_core  (done_core),
        .o_done_id    (done_id),
        .o_done_late  (done_late),
        .o_miss_count (miss_count),
        .o_drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input logic run, input logic crit, input logic [7:0] id,
                                        input logic [15:0] d, input logic [15:0] e);
        return {run, crit, id, d, e};
    endfunction

    function automatic logic [W-1:0] slot_of(input logic [W*CORE-1:0] v, input int c);
        return v[W*c +: W];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        while (tick !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("tick_timeout", 64'(n < 20), 64'(1'b1));
    endtask

    task automatic put(input int c, input logic [W-1:0] s);
        slots_in[W*c +: W] = s;
    endtask

    task automatic chk_evt(input string tag, input logic [3:0] c, input logic [7:0] id, input logic late);
        chk({tag, "_valid"}, 64'(done_valid), 64'(1'b1));
        chk({tag, "_core"},  64'(done_core),  64'(c));
        chk({tag, "_id"},    64'(done_id),    64'(id));
        chk({tag, "_late"},  64'(done_late),  64'(late));
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b1;
        en         = 1'b0;
        slots_in   = '0;
        done_ready = 1'b0;
        step();
        step();
        chk("rst_tick",  64'(tick),       64'(1'b0));
        chk("rst_valid", 64'(done_valid), 64'(1'b0));
        chk("rst_core",  64'(done_core),  64'(4'd0));
        chk("rst_id",    64'(done_id),    64'(8'd0));
        chk("rst_late",  64'(done_late),  64'(1'b0));
        chk("rst_miss",  64'(miss_count), 64'(16'd0));
        chk("rst_drop",  64'(drop_count), 64'(16'd0));

        // Tick cadence: edges 4, 8, 12 after enable, then a 2-cycle stall.
        rst = 1'b0;
        en  = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("cad_%0d", k), 64'(tick), 64'((k % 4) == 0));
        end
        en = 1'b0;
        step();
        chk("stall_13", 64'(tick), 64'(1'b0));
        step();
        chk("stall_14", 64'(tick), 64'(1'b0));
        en = 1'b1;
        for (int k = 15; k <= 18; k++) begin
            step();
            chk($sformatf("cad_%0d", k), 64'(tick), 64'(k == 18));
        end

        // Aging and pass-through.
        wait_tick();
        put(3, mk(1'b1, 1'b0, 8'h21, 16'd10, 16'd5));
        put(1, mk(1'b0, 1'b1, 8'h55, 16'd0, 16'd0));
        #1;
        chk("age_c3",  64'(slot_of(slots_out, 3)), 64'(mk(1'b1, 1'b0, 8'h21, 16'd9, 16'd4)));
        chk("pass_c1", 64'(slot_of(slots_out, 1)), 64'(mk(1'b0, 1'b1, 8'h55, 16'd0, 16'd0)));
        step();
        slots_in = '0;
        chk("age_noevt", 64'(done_valid), 64'(1'b0));

        // On-time completion on core 0.
        wait_tick();
        put(0, mk(1'b1, 1'b0, 8'h33, 16'd3, 16'd1));
        #1;
        chk("ontime_slot", 64'(slot_of(slots_out, 0)), 64'(mk(1'b0, 1'b0, 8'h33, 16'd0, 16'd0)));
        step();
        slots_in = '0;
        chk_evt("ontime", 4'd0, 8'h33, 1'b0);
        chk("ontime_miss", 64'(miss_count), 64'(16'd0));
        done_ready = 1'b1;
        step();
        done_ready = 1'b0;
        chk("ontime_drain", 64'(done_valid), 64'(1'b0));

        // Abort on core 5: deadline runs out before execution.
        wait_tick();
        put(5, mk(1'b1, 1'b1, 8'h44, 16'd1, 16'd7));
        #1;
        chk("abort_slot", 64'(slot_of(slots_out, 5)), 64'(mk(1'b0, 1'b1, 8'h44, 16'd0, 16'd0)));
        step();
        slots_in = '0;
        chk_evt("abort", 4'd5, 8'h44, 1'b1);
        chk("abort_miss", 64'(miss_count), 64'(16'd1));
        done_ready = 1'b1;
        step();
        done_ready = 1'b0;
        chk("abort_drain", 64'(done_valid), 64'(1'b0));

        // Overflow on core 4: second completion is dropped.
        wait_tick();
        put(4, mk(1'b1, 1'b0, 8'h71, 16'd5, 16'd1));
        step();
        slots_in = '0;
        chk_evt("ovf1", 4'd4, 8'h71, 1'b0);
        wait_tick();
        put(4, mk(1'b1, 1'b0, 8'h72, 16'd5, 16'd0));
        step();
        slots_in = '0;
        chk_evt("ovf2", 4'd4, 8'h71, 1'b0);
        chk("ovf_drop", 64'(drop_count), 64'(16'd1));
        chk("ovf_miss", 64'(miss_count), 64'(16'd1));
        rst = 1'b1;
        #1;
        chk("rst2_valid", 64'(done_valid), 64'(1'b0));
        chk("rst2_miss",  64'(miss_count), 64'(16'd0));
        chk("rst2_drop",  64'(drop_count), 64'(16'd0));
        step();
        rst = 1'b0;

        // Burst on cores 2, 9, 15: held while not ready, then drained in order.
        wait_tick();
        put(2,  mk(1'b1, 1'b0, 8'h02, 16'd5, 16'd1));
        put(9,  mk(1'b1, 1'b0, 8'h09, 16'd0, 16'd1));
        put(15, mk(1'b1, 1'b0, 8'h0F, 16'd5, 16'd1));
        step();
        slots_in = '0;
        chk_evt("burst_hold0", 4'd2, 8'h02, 1'b0);
        chk("burst_miss", 64'(miss_count), 64'(16'd1));
        step();
        step();
        chk_evt("burst_hold2", 4'd2, 8'h02, 1'b0);
        done_ready = 1'b1;
        step();
        chk_evt("burst_c9", 4'd9, 8'h09, 1'b1);
        step();
        chk_evt("burst_c15", 4'd15, 8'h0F, 1'b0);
        step();
        chk("burst_drain", 64'(done_valid), 64'(1'b0));
        done_ready = 1'b0;

        // Accept and new capture on the same core in one edge: new event wins.
        wait_tick();
        put(6, mk(1'b1, 1'b0, 8'hA1, 16'd4, 16'd1));
        step();
        slots_in = '0;
        chk_evt("same_first", 4'd6, 8'hA1, 1'b0);
        wait_tick();
        put(6, mk(1'b1, 1'b0, 8'hA2, 16'd4, 16'd1));
        done_ready = 1'b1;
        step();
        slots_in   = '0;
        done_ready = 1'b0;
        chk_evt("same_new", 4'd6, 8'hA2, 1'b0);
        chk("same_drop", 64'(drop_count), 64'(16'd0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/core_executor.md
# core_executor

Emulates execution on the CORE processors for the hardware scheduler. It generates the periodic time tick (scheduler subtract strobe) and, on each tick, ages every running slot's execution and deadline fields. It retires finished or hopeless tasks by clearing their running flag and returns the updated slot vector to the scheduler's running-task input. Each retirement is reported through a round-robin valid/ready completion port with a deadline-miss indication and statistics counters.

## Interface
- W, 42, slot width; bit W-1 running flag, [40] critical flag, [39:32] ID, [31:16] relative deadline, [15:0] execution time
- CORE, 16, processor count; power of two, at most 256
- TICK_DIV, 16, clk cycles per tick; must be at least 2
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  tick counter enable
- slots_in  in  W*CORE  slot vector from scheduler output; slot c occupies [W*c+W-1 : W*c]
- slots_out  out  W*CORE  aged slot vector, to scheduler running-task input
- tick  out  1  one-cycle subtract strobe
- done_valid  out  1  completion event available
- done_ready  in  1  consumer accepts event
- done_core  out  log2(CORE)  core index of event
- done_id  out  8  task ID
- done_late  out  1  1 = deadline missed (task aborted)
- miss_count  out  16  saturating count of late events
- drop_count  out  16  saturating count of events lost to overflow

## Operation
- Tick counter, range 0..TICK_DIV-1:
  - Increments while en=1; holds while en=0.
  - tick is registered and high for exactly the cycle after the counter wraps, so ticks are TICK_DIV cycles apart.
- slots_out is combinational from slots_in. Per slot:
  - Running flag 0: pass through unchanged.
  - Running flag 1, exec (e) ≤ 1: complete. Output flag 0, e=0, d=0; ID and critical kept. Late iff deadline (d) = 0.
  - Running flag 1, e ≥ 2 and d ≤ 1: abort, late. Output is the same as complete.
  - Otherwise: e-1 and d-1; flag, ID and critical kept.
- The aged values only matter when tick=1, because the scheduler latches slots_out on tick. No wraps are possible, since every 16-bit subtraction happens only when the operand is at least 1.
- Event capture, on clk edge with tick=1, for each completing or aborting core c:
  - If pend[c]=0: set pend[c], store id[c] and late[c].
  - If pend[c]=1: keep the old event and increment drop_count.
  - Late events captured increment miss_count; dropped events do not.
  - Both counters saturate at 16'hFFFF.
- Serializer:
  - done_valid = |pend.
  - Selected core is the first pend bit at or above rr_ptr, wrapping around.
  - Outputs come from the stored arrays and are held stable while valid && !ready.
  - On accept (valid and ready): clear pend[sel] and set rr_ptr = sel+1 (mod CORE).
- Simultaneous clear and set on the same core in one edge: the new capture wins. pend stays 1 with the new data and nothing is dropped.

## Timing
- Reset values: counter 0, tick 0, pend 0, rr_ptr 0, done_valid 0, done_core 0, done_id 0, done_late 0, miss_count 0, drop_count 0.
- Reset mid-operation discards all pending events immediately.
- First tick occurs TICK_DIV cycles after the first cycle with en=1 following reset.
- Event latency: a tick in cycle T gives done_valid=1 in cycle T+1.
- Throughput: one event accepted per cycle. A burst of N simultaneous completions drains in N cycles when ready is held at 1.
- done_* are registered-state driven. No combinational path exists from done_ready to done_valid.

## Structure
- Shared package core_exec_pkg holds:
  - Field constants RUN_BIT, CRIT_BIT, ID_HI/LO, DL_HI/LO, EX_HI/LO.
  - The function age_slot, which returns the next slot plus retire and late flags.
- One sub-module: completion_arbiter, a parameterised round-robin first-one picker taking pend and rr_ptr and returning sel and any.
- Remaining logic is flat in core_executor: tick counter, capture arrays, counters.

## Test plan
- Tick cadence: TICK_DIV=4, en=1 after reset → tick high in cycles 4, 8, 12. Drop en for 2 cycles → next tick is delayed by 2.
- Aging: core 3 = {run 1, ID 8'h21, d=10, e=5} → on tick, slots_out core 3 = {1, 21, 9, 4}. No event.
- On-time completion: core 0 {d=3, e=1}, tick → slot flag 0, e=0, d=0. Next cycle: done_valid=1, done_core=0, done_id matches, done_late=0. miss_count stays 0.
- Abort: core 5 {d=1, e=7}, tick → retired. Event done_late=1; miss_count=1.
- Burst and round robin: cores 2, 9, 15 complete on one tick with done_ready=1 → events emitted for 2, 9, 15 in consecutive cycles. With done_ready=0 throughout, outputs stay fixed on core 2.
- Overflow: core 4 completes and is not accepted; a new task on core 4 completes at the next tick → original event retained and drop_count=1. Reset asserted afterwards → done_valid=0 and both counters 0.
